pipeline_hazard_ctrl: RTL

//  Sequences the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM) and PC.

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for a five-stage MIPS pipeline: load-use bubbles, redirect squash,
// data-memory freeze with sticky watchdog. Optional perf counters under HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    input  logic        ex_Jump,
    input  logic        mem_branch_taken,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_redirect,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_write,
    output logic        exmem_flush,
    output logic        mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {INIT, RUN, FLUSH, MEM_WAIT} state_t;

    localparam logic [2:0] FCNT_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI      = (FLUSH_CYCLES > 1);
    localparam logic [7:0] TIMEOUT_W  = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic       redirect, load_use;

    assign redirect = ex_Jump | mem_branch_taken;
    assign load_use = ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            fcnt        <= '0;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            wcnt  <= wcnt_nxt;
            // wcnt_nxt is zero outside a stall and MEM_TIMEOUT >= 2, so only a real wait can match
            if (wcnt_nxt == TIMEOUT_W)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        wcnt_nxt  = wcnt;
        case (state)
            INIT: state_nxt = RUN;
            RUN, FLUSH: begin
                if (!mem_ready) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = 8'd1;
                end else if (redirect) begin
                    state_nxt = MULTI ? FLUSH : RUN;
                    fcnt_nxt  = MULTI ? FCNT_LOAD : 3'd0;
                end else if (state == FLUSH) begin
                    if (fcnt <= 3'd1) begin
                        state_nxt = RUN;
                        fcnt_nxt  = 3'd0;
                    end else begin
                        fcnt_nxt = fcnt - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    wcnt_nxt = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
                end else begin
                    wcnt_nxt = 8'd0;
                    if (redirect) begin
                        state_nxt = MULTI ? FLUSH : RUN;
                        fcnt_nxt  = MULTI ? FCNT_LOAD : 3'd0;
                    end else begin
                        // resume an interrupted squash window
                        state_nxt = (fcnt != 3'd0) ? FLUSH : RUN;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        pc_redirect = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b0;
        exmem_flush = 1'b0;
        if (state == INIT) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_ready) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            if (redirect) begin
                pc_redirect = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = mem_branch_taken;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            if (state == FLUSH)
                ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_ev, flush_ev;
    assign stall_ev = (state != INIT) && (!mem_ready || (!redirect && load_use));
    assign flush_ev = (state != INIT) && mem_ready && redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_ev && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            if (flush_ev && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
